// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: resolves freeze/flush/stall/run by strict priority,
// keeps saturating performance counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             IMEM_BUSY,
   input  logic             DMEM_BUSY,
   input  logic             BRANCH_TAKEN,
   input  logic             EX_MEMREAD,
   input  logic [4:0]       EX_RD,
   input  logic [4:0]       ID_RS1,
   input  logic [4:0]       ID_RS2,
   input  logic             ID_USES_RS1,
   input  logic             ID_USES_RS2,
   output logic             BUSY_WAIT,
   output logic             PC_WRITE,
   output logic             STALL_IF_ID,
   output logic             BUBBLE_ID_EX,
   output logic             FLUSH_IF_ID,
   output logic             FLUSH_ID_EX,
   output logic [1:0]       STATE,
   output logic [CNT_W-1:0] STALL_COUNT,
   output logic [CNT_W-1:0] FLUSH_COUNT,
   output logic [CNT_W-1:0] FREEZE_COUNT,
   output logic             MEM_TIMEOUT
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_STALL  = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_FREEZE = 2'd3
   } state_e;

   localparam int unsigned        RUN_W   = $clog2(TIMEOUT + 1);
   localparam logic [RUN_W-1:0]   RUN_MAX = RUN_W'(TIMEOUT);
   localparam logic [RUN_W-1:0]   RUN_TM1 = RUN_W'(TIMEOUT - 1);
   localparam logic [RUN_W-1:0]   RUN_ONE = RUN_W'(1);
   localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

   state_e             cls, state_q;
   logic               load_use;
   logic               flush_pend_q, flush_pend_d;
   logic [RUN_W-1:0]   run_q, run_d;
   logic               timeout_q, timeout_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0]   freeze_cnt_q, freeze_cnt_d;

   always_comb begin
      load_use = EX_MEMREAD && (EX_RD != 5'd0) &&
                 ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                  (ID_USES_RS2 && (ID_RS2 == EX_RD)));
      if (IMEM_BUSY || DMEM_BUSY)
         cls = ST_FREEZE;
      else if (BRANCH_TAKEN || flush_pend_q)
         cls = ST_FLUSH;
      else if (load_use)
         cls = ST_STALL;
      else
         cls = ST_RUN;
   end

   always_comb begin
      BUSY_WAIT    = 1'b0;
      PC_WRITE     = 1'b0;
      STALL_IF_ID  = 1'b0;
      BUBBLE_ID_EX = 1'b0;
      FLUSH_IF_ID  = 1'b0;
      FLUSH_ID_EX  = 1'b0;
      if (!RESET) begin
         // Held in reset the pipeline registers are forced to NOP.
         FLUSH_IF_ID = 1'b1;
         FLUSH_ID_EX = 1'b1;
      end else begin
         unique case (cls)
            ST_FREEZE: begin
               BUSY_WAIT   = 1'b1;
               STALL_IF_ID = 1'b1;
            end
            ST_FLUSH: begin
               FLUSH_IF_ID = 1'b1;
               FLUSH_ID_EX = 1'b1;
               PC_WRITE    = 1'b1;
            end
            ST_STALL: begin
               STALL_IF_ID  = 1'b1;
               BUBBLE_ID_EX = 1'b1;
            end
            default: PC_WRITE = 1'b1;
         endcase
      end
   end

   always_comb begin
      flush_pend_d = 1'b0;
      run_d        = '0;
      timeout_d    = timeout_q;
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      freeze_cnt_d = freeze_cnt_q;
      unique case (cls)
         ST_FREEZE: begin
            // A branch resolved while frozen is remembered until the freeze ends.
            flush_pend_d = flush_pend_q || BRANCH_TAKEN;
            run_d        = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;
            timeout_d    = timeout_q || (run_q >= RUN_TM1);
            if (freeze_cnt_q != '1) freeze_cnt_d = freeze_cnt_q + CNT_ONE;
         end
         ST_FLUSH: begin
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_ONE;
         end
         ST_STALL: begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q      <= ST_RUN;
         flush_pend_q <= 1'b0;
         run_q        <= '0;
         timeout_q    <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         freeze_cnt_q <= '0;
      end else begin
         state_q      <= cls;
         flush_pend_q <= flush_pend_d;
         run_q        <= run_d;
         timeout_q    <= timeout_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         freeze_cnt_q <= freeze_cnt_d;
      end
   end

   assign STATE        = state_q;
   assign STALL_COUNT  = stall_cnt_q;
   assign FLUSH_COUNT  = flush_cnt_q;
   assign FREEZE_COUNT = freeze_cnt_q;
   assign MEM_TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic, two
// instances (default widths, and CNT_W=4/TIMEOUT=8) against a rule-level model.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ib, db, br, mr, u1, u2;
   logic [4:0] rd, rs1, rs2;

   logic        a_bw, a_pcw, a_stl, a_bub, a_fif, a_fie, a_to;
   logic [1:0]  a_st;
   logic [15:0] a_sc, a_fc, a_zc;
   logic        b_bw, b_pcw, b_stl, b_bub, b_fif, b_fie, b_to;
   logic [1:0]  b_st;
   logic [3:0]  b_sc, b_fc, b_zc;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int m_pend, m_run, m_state;
   int ma_stall, ma_flush, ma_freeze, ma_to;
   int mb_stall, mb_flush, mb_freeze, mb_to;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.CNT_W(16), .TIMEOUT(256)) u_dut (
      .CLK(clk), .RESET(rst_n), .IMEM_BUSY(ib), .DMEM_BUSY(db), .BRANCH_TAKEN(br),
      .EX_MEMREAD(mr), .EX_RD(rd), .ID_RS1(rs1), .ID_RS2(rs2),
      .ID_USES_RS1(u1), .ID_USES_RS2(u2), .BUSY_WAIT(a_bw), .PC_WRITE(a_pcw),
      .STALL_IF_ID(a_stl), .BUBBLE_ID_EX(a_bub), .FLUSH_IF_ID(a_fif),
      .FLUSH_ID_EX(a_fie), .STATE(a_st), .STALL_COUNT(a_sc), .FLUSH_COUNT(a_fc),
      .FREEZE_COUNT(a_zc), .MEM_TIMEOUT(a_to));

   pipeline_hazard_ctrl #(.CNT_W(4), .TIMEOUT(8)) u_sat (
      .CLK(clk), .RESET(rst_n), .IMEM_BUSY(ib), .DMEM_BUSY(db), .BRANCH_TAKEN(br),
      .EX_MEMREAD(mr), .EX_RD(rd), .ID_RS1(rs1), .ID_RS2(rs2),
      .ID_USES_RS1(u1), .ID_USES_RS2(u2), .BUSY_WAIT(b_bw), .PC_WRITE(b_pcw),
      .STALL_IF_ID(b_stl), .BUBBLE_ID_EX(b_bub), .FLUSH_IF_ID(b_fif),
      .FLUSH_ID_EX(b_fie), .STATE(b_st), .STALL_COUNT(b_sc), .FLUSH_COUNT(b_fc),
      .FREEZE_COUNT(b_zc), .MEM_TIMEOUT(b_to));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Class by rule: 3 freeze, 2 flush, 1 stall, 0 run
   function automatic int cls_of();
      if (ib || db) return 3;
      if (br || m_pend != 0) return 2;
      if (mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd))) return 1;
      return 0;
   endfunction

   function automatic int sat(input int v, input int maxv);
      return (v + 1 > maxv) ? maxv : v + 1;
   endfunction

   task automatic model_reset();
      m_pend = 0; m_run = 0; m_state = 0;
      ma_stall = 0; ma_flush = 0; ma_freeze = 0; ma_to = 0;
      mb_stall = 0; mb_flush = 0; mb_freeze = 0; mb_to = 0;
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, ".state_a"}, 32'(a_st), m_state);
      chk({tag, ".state_b"}, 32'(b_st), m_state);
      chk({tag, ".stall_a"}, 32'(a_sc), ma_stall);
      chk({tag, ".flush_a"}, 32'(a_fc), ma_flush);
      chk({tag, ".freeze_a"}, 32'(a_zc), ma_freeze);
      chk({tag, ".tmo_a"}, 32'(a_to), ma_to);
      chk({tag, ".stall_b"}, 32'(b_sc), mb_stall);
      chk({tag, ".flush_b"}, 32'(b_fc), mb_flush);
      chk({tag, ".freeze_b"}, 32'(b_zc), mb_freeze);
      chk({tag, ".tmo_b"}, 32'(b_to), mb_to);
   endtask

   task automatic chk_ctrl(input string tag, input int c, input logic rst);
      logic [5:0] exp, oa, ob;
      if (rst) exp = 6'b000011;
      else case (c)
         3:       exp = 6'b101000;
         2:       exp = 6'b010011;
         1:       exp = 6'b001100;
         default: exp = 6'b010000;
      endcase
      // {BUSY_WAIT, PC_WRITE, STALL_IF_ID, BUBBLE_ID_EX, FLUSH_IF_ID, FLUSH_ID_EX}
      oa = {a_bw, a_pcw, a_stl, a_bub, a_fif, a_fie};
      ob = {b_bw, b_pcw, b_stl, b_bub, b_fif, b_fie};
      chk({tag, ".ctrl_a"}, 32'(oa), 32'(exp));
      chk({tag, ".ctrl_b"}, 32'(ob), 32'(exp));
   endtask

   task automatic drive(input logic i_ib, i_db, i_br, i_mr, input logic [4:0] i_rd,
                        i_rs1, i_rs2, input logic i_u1, i_u2);
      ib = i_ib; db = i_db; br = i_br; mr = i_mr; rd = i_rd;
      rs1 = i_rs1; rs2 = i_rs2; u1 = i_u1; u2 = i_u2;
   endtask

   task automatic step(input string tag);
      int c;
      #1;
      c = cls_of();
      chk_ctrl(tag, c, 1'b0);
      @(posedge clk);
      case (c)
         3: begin
            ma_freeze = sat(ma_freeze, 65535);
            mb_freeze = sat(mb_freeze, 15);
            m_run++;
            if (m_run >= 256) ma_to = 1;
            if (m_run >= 8) mb_to = 1;
            if (br) m_pend = 1;
         end
         2: begin
            ma_flush = sat(ma_flush, 65535); mb_flush = sat(mb_flush, 15);
            m_run = 0; m_pend = 0;
         end
         1: begin
            ma_stall = sat(ma_stall, 65535); mb_stall = sat(mb_stall, 15);
            m_run = 0;
         end
         default: m_run = 0;
      endcase
      m_state = c;
      #1;
      chk_regs(tag);
   endtask

   task automatic chk_reset(input string tag);
      chk_ctrl(tag, 0, 1'b1);
      chk_regs(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #12;
      chk_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      drive(0, 0, 0, 1, 5, 0, 5, 0, 1); step("loaduse");
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("run1");
      drive(0, 0, 0, 1, 0, 0, 0, 0, 1); step("load_x0");
      drive(0, 0, 1, 1, 5, 5, 0, 1, 0); step("br_hazard");
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("run2");

      drive(0, 1, 0, 0, 0, 0, 0, 0, 0); step("frz1");
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0); step("frz2_br");
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0); step("frz3");
      chk("frz_count3", 32'(a_zc), 3);
      drive(0, 0, 0, 1, 7, 7, 0, 1, 0); step("pend_flush");
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("after_flush");

      drive(1, 0, 1, 0, 0, 0, 0, 0, 0); step("frz_br_held");
      drive(0, 0, 1, 0, 0, 0, 0, 0, 0); step("exit_flush");
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("exit_run");

      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 0, 1, 5'(3 + i % 20), 5'(3 + i % 20), 0, 1, 0);
         step("sat_stall");
      end
      chk("sat_b_15", 32'(b_sc), 15);

      for (int i = 0; i < 256; i++) begin
         drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
         step("tmo_frz");
         if (i == 254) chk("tmo_a_before", 32'(a_to), 0);
      end
      chk("tmo_a_set", 32'(a_to), 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("tmo_hold1");
      step("tmo_hold2");

      drive(1, 0, 1, 0, 0, 0, 0, 0, 0); step("mid_frz");
      #2 rst_n = 1'b0;
      model_reset();
      #1 chk_reset("async_rst");
      @(posedge clk); #1;
      chk_reset("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step("first_edge");

      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 4) == 0), 1'($urandom),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
         step("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the saturating performance counters.
REQ-002 Parameter: TIMEOUT, default 256, number of consecutive freeze cycles that sets MEM_TIMEOUT.
REQ-003 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-005 IMEM_BUSY, DMEM_BUSY  input  1 each  instruction/data memory busy-wait.
REQ-006 BRANCH_TAKEN  input  1  EX-stage branch/jump resolved taken.
REQ-007 EX_MEMREAD  input  1  the instruction in EX is a load.
REQ-008 EX_RD  input  5  destination register of the EX instruction.
REQ-009 ID_RS1, ID_RS2  input  5 each  source registers of the ID instruction.
REQ-010 ID_USES_RS1, ID_USES_RS2  input  1 each  the ID instruction reads that source.
REQ-011 BUSY_WAIT  output  1  freezes every pipeline register.
REQ-012 PC_WRITE  output  1  PC register load enable.
REQ-013 STALL_IF_ID  output  1  IF/ID register holds its value.
REQ-014 BUBBLE_ID_EX, FLUSH_IF_ID, FLUSH_ID_EX  output  1 each  zero the ID/EX register, or clear the IF/ID or ID/EX register to NOP.
REQ-015 STATE  output  2  registered action of the previous cycle: 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE.
REQ-016 STALL_COUNT, FLUSH_COUNT, FREEZE_COUNT  output  CNT_W each  performance counters.
REQ-017 MEM_TIMEOUT  output  1  sticky memory-timeout flag.

Function
REQ-018 Control outputs (REQ-011..014) are combinational from the current inputs and the flush_pending register, evaluated each cycle in the strict priority of REQ-019..022.
REQ-019 FREEZE (IMEM_BUSY|DMEM_BUSY): BUSY_WAIT=1, STALL_IF_ID=1, PC_WRITE=0, all flush/bubble outputs 0; if BRANCH_TAKEN=1, set flush_pending at the edge.
REQ-020 FLUSH (not FREEZE, BRANCH_TAKEN|flush_pending): FLUSH_IF_ID=1, FLUSH_ID_EX=1, PC_WRITE=1, STALL_IF_ID=0; clear flush_pending at the edge; any load-use hazard is ignored.
REQ-021 STALL (no higher class; load-use = EX_MEMREAD & EX_RD!=0 & ((ID_USES_RS1 & ID_RS1==EX_RD) | (ID_USES_RS2 & ID_RS2==EX_RD))): STALL_IF_ID=1, PC_WRITE=0, BUBBLE_ID_EX=1.
REQ-022 RUN (none of the above): PC_WRITE=1, all other control outputs 0.
REQ-023 STATE is loaded at every rising edge with the code of the class taken in that cycle.
REQ-024 A hazard on EX_RD=0 (x0) never stalls.
REQ-025 A load-use stall lasts exactly one cycle per hazard because the bubble removes the load from EX; back-to-back stalls occur only if the inputs present a new hazard.
REQ-026 FREEZE_COUNT, FLUSH_COUNT and STALL_COUNT each increment by 1 per cycle of their class.
REQ-027 Every counter saturates at 2^CNT_W-1 and never wraps.
REQ-028 An internal freeze-run counter increments each consecutive FREEZE cycle and clears on any non-FREEZE cycle.
REQ-029 MEM_TIMEOUT sets on the edge where the freeze-run counter reaches TIMEOUT and stays 1 until reset.
REQ-030 Freeze is not aborted by MEM_TIMEOUT.
REQ-031 A branch that is taken while frozen and still asserted at freeze exit produces exactly one FLUSH cycle.

Reset
REQ-032 While RESET=0: BUSY_WAIT=0, PC_WRITE=0, STALL_IF_ID=0, BUBBLE_ID_EX=0, FLUSH_IF_ID=1, FLUSH_ID_EX=1.
REQ-033 While RESET=0: STATE=0, all counters=0, MEM_TIMEOUT=0, flush_pending=0, freeze-run counter=0.
REQ-034 Reset asserted mid-FREEZE or mid-STALL discards the pending action.
REQ-035 The first edge after RESET rises evaluates normally per REQ-019..022.

Verification
REQ-036 Load-use test: EX_MEMREAD=1, EX_RD=5, ID_RS2=5, ID_USES_RS2=1 for one cycle -> STALL_IF_ID=1, BUBBLE_ID_EX=1, PC_WRITE=0, STALL_COUNT 0->1, STATE=1 after the edge.
REQ-037 Load to x0: same as REQ-036 but EX_RD=0 -> RUN, PC_WRITE=1, STALL_COUNT unchanged.
REQ-038 Branch plus hazard: BRANCH_TAKEN=1 together with a load-use hazard -> FLUSH_IF_ID=FLUSH_ID_EX=1, BUBBLE_ID_EX=0, FLUSH_COUNT=1, STALL_COUNT=0.
REQ-039 Branch during freeze: DMEM_BUSY=1 for 3 cycles with BRANCH_TAKEN=1 in the 2nd cycle, then BRANCH_TAKEN=0 -> FREEZE_COUNT=3, then exactly one FLUSH cycle, then RUN.
REQ-040 Timeout: IMEM_BUSY=1 for 256 cycles (TIMEOUT=256) -> MEM_TIMEOUT=1 from the 256th edge, held after IMEM_BUSY=0; RESET=0 pulse -> MEM_TIMEOUT=0 and all counters 0 immediately, without a clock edge.
REQ-041 Saturation: CNT_W=4 with 20 consecutive stall cycles -> STALL_COUNT=15, no wrap.
